simd_mac_array: RTL and testbench

- Parametrised multi-lane multiply-accumulate engine with an HLS-style block-level control handshake (ap_start/ap_ready/ap_done/ap_idle/ap_continue) and a clock enable.
- Per task it accumulates LANES independent dot products over a runtime length of input beats, with an in_vld/in_rdy stream on the operands.
- The result is held until the consumer acknowledges it.
- Sits in the compute datapath as the next-generation GEMM MAC primitive, mapped one lane per DSP slice.

---
 rtl/simd_mac_pkg.sv | 22 ++
 rtl/simd_mac_array_if.sv | 37 +++
 rtl/simd_mac_lane.sv | 83 ++++++++
 rtl/simd_mac_array.sv | 120 ++++++++++++
 tb/tb_simd_mac_array.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_mac_pkg.sv
// Shared definitions for the SIMD MAC array.
// FSM state encodings, the drain length, and the helper that locates a lane
// inside a packed multi-lane bus.
package simd_mac_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Two pipeline stages must empty before the result is final
    localparam int unsigned DRAIN_CYC = 2;
    localparam int unsigned DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    // Base bit index of lane 'lane' in a bus packed at 'w' bits per lane
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/simd_mac_array_if.sv
// Block-level control and operand/result bus of the SIMD MAC array.
// master: task issuer / operand source / result consumer.
// slave : the MAC engine.
// Signals: ap_ce, ap_start, ap_continue, len, a_data, b_data, in_vld (to engine);
//          in_rdy, ap_idle, ap_ready, ap_done, acc_out, acc_ap_vld, ovf (from engine).
interface simd_mac_array_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 21,
    parameter int unsigned LEN_W  = 8
);
    logic                      ap_ce;
    logic                      ap_start;
    logic                      ap_continue;
    logic [LEN_W-1:0]          len;
    logic [LANES*DATA_W-1:0]   a_data;
    logic [LANES*DATA_W-1:0]   b_data;
    logic                      in_vld;
    logic                      in_rdy;
    logic                      ap_idle;
    logic                      ap_ready;
    logic                      ap_done;
    logic [LANES*ACC_W-1:0]    acc_out;
    logic                      acc_ap_vld;
    logic [LANES-1:0]          ovf;

    modport master (
        output ap_ce, ap_start, ap_continue, len, a_data, b_data, in_vld,
        input  in_rdy, ap_idle, ap_ready, ap_done, acc_out, acc_ap_vld, ovf
    );

    modport slave (
        input  ap_ce, ap_start, ap_continue, len, a_data, b_data, in_vld,
        output in_rdy, ap_idle, ap_ready, ap_done, acc_out, acc_ap_vld, ovf
    );

endinterface

// File: rtl/simd_mac_lane.sv
// One MAC lane: stage 1 registers the operands of an accepted beat, stage 2
// adds their extended product into the accumulator and tracks sticky overflow.
// Ports: ap_clk, ap_rst (async, active-high), ce (freeze when low),
//        clr (task accept: clear acc/ovf/pipeline), beat (operands valid),
//        a, b (operands), acc (running sum), ovf (sticky overflow).
// ACC_W must exceed 2*DATA_W.
(* use_dsp = "yes" *)
module simd_mac_lane #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 21,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ce,
    input  logic              clr,
    input  logic              beat,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              s1_vld_q;
    logic [PROD_W-1:0] a_ext_c;
    logic [PROD_W-1:0] b_ext_c;
    logic [PROD_W-1:0] prod_c;
    logic [ACC_W-1:0]  prod_ext_c;
    logic [ACC_W:0]    sum_c;
    logic              ovf_u_c;
    logic              ovf_s_c;

    // Operands extended to full product width so the low PROD_W bits of the
    // multiply are correct in either signedness
    assign a_ext_c = SIGNED ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    assign b_ext_c = SIGNED ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    assign prod_c  = a_ext_c * b_ext_c;

    assign prod_ext_c = SIGNED ? {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c}
                               : {{(ACC_W-PROD_W){1'b0}}, prod_c};

    assign sum_c = {1'b0, acc} + {1'b0, prod_ext_c};

    // Unsigned: carry out. Signed: like-signed operands giving a different-signed sum.
    assign ovf_u_c = sum_c[ACC_W];
    assign ovf_s_c = (acc[ACC_W-1] == prod_ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1]);

    // Stage 1: operand capture
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            s1_vld_q <= 1'b0;
        end else if (ce) begin
            if (beat) begin
                a_q <= a;
                b_q <= b;
            end
            s1_vld_q <= beat & ~clr;
        end
    end

    // Stage 2: accumulate and sticky overflow
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (ce) begin
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (s1_vld_q) begin
                acc <= sum_c[ACC_W-1:0];
                ovf <= ovf | (SIGNED ? ovf_s_c : ovf_u_c);
            end
        end
    end

endmodule

// File: rtl/simd_mac_array.sv
// Multi-lane multiply-accumulate engine with HLS-style block control.
// Each task accepts 'len' operand beats and produces LANES independent dot
// products, held on acc_out until ap_continue.
// Ports: ap_clk, ap_rst (async, active-high), io (simd_mac_array_if.slave):
//        ap_ce, ap_start, ap_continue, len, a_data, b_data, in_vld in;
//        in_rdy, ap_idle, ap_ready, ap_done, acc_out, acc_ap_vld, ovf out.
// ap_ready is the combinational accept strobe; every other output is a flop.
module simd_mac_array
    import simd_mac_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 21,
    parameter int unsigned LEN_W  = 8,
    parameter bit          SIGNED = 1'b0
) (
    input logic             ap_clk,
    input logic             ap_rst,
    simd_mac_array_if.slave io
);

    logic [STATE_W-1:0]     state_q;
    logic [STATE_W-1:0]     state_d;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       cnt_q;
    logic [DRAIN_W-1:0]     drain_q;
    logic                   idle_q;
    logic                   rdy_q;
    logic                   done_q;
    logic                   accept_c;
    logic                   beat_c;
    logic [LANES*ACC_W-1:0] lane_acc;
    logic [LANES-1:0]       lane_ovf;

    // Next state, task accept and beat strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        beat_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.ap_ce && io.ap_start && !ap_rst) begin
                    accept_c = 1'b1;
                    state_d  = (io.len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                beat_c = io.ap_ce & io.in_vld;
                // Leaving on the edge of the final beat keeps in_rdy from admitting an extra one
                if (beat_c && (cnt_q == LEN_W'(len_q - 1'b1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (io.ap_ce && (drain_q == DRAIN_W'(DRAIN_CYC - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (io.ap_ce && io.ap_continue) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            idle_q  <= 1'b1;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (io.ap_ce) begin
            state_q <= state_d;
            idle_q  <= (state_d == ST_IDLE);
            rdy_q   <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            if (accept_c) begin
                len_q <= io.len;
                cnt_q <= '0;
            end else if (beat_c) begin
                cnt_q <= LEN_W'(cnt_q + 1'b1);
            end
            drain_q <= (state_q == ST_DRAIN) ? DRAIN_W'(drain_q + 1'b1) : '0;
        end
    end

    // One MAC lane per operand slice
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
        ) u_lane (
            .ap_clk (ap_clk),
            .ap_rst (ap_rst),
            .ce     (io.ap_ce),
            .clr    (accept_c),
            .beat   (beat_c),
            .a      (io.a_data[lane_lsb(i, DATA_W) +: DATA_W]),
            .b      (io.b_data[lane_lsb(i, DATA_W) +: DATA_W]),
            .acc    (lane_acc[lane_lsb(i, ACC_W) +: ACC_W]),
            .ovf    (lane_ovf[i])
        );
    end

    assign io.in_rdy     = rdy_q;
    assign io.ap_idle    = idle_q;
    assign io.ap_ready   = accept_c;
    assign io.ap_done    = done_q;
    assign io.acc_ap_vld = done_q;
    assign io.acc_out    = lane_acc;
    assign io.ovf        = lane_ovf;

endmodule

// File: tb/tb_simd_mac_array.sv
// Scoreboard bench for simd_mac_array: an unsigned and a signed instance see
// the same stimulus; expected results are queued per instance and checked by
// a monitor when acc_ap_vld rises.
module tb_simd_mac_array;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 21;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned AW     = LANES * ACC_W;
    localparam int unsigned DW     = LANES * DATA_W;

    typedef logic [AW-1:0] acc_bus_t;
    typedef logic [DW-1:0] dat_bus_t;
    typedef struct packed {
        acc_bus_t         acc;
        logic [LANES-1:0] ovf;
    } exp_t;

    localparam dat_bus_t A_BASIC   = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam dat_bus_t B_TWO     = {4{8'd2}};
    localparam acc_bus_t EXP_BASIC = {21'd32, 21'd24, 21'd16, 21'd8};
    localparam acc_bus_t EXP_PART  = {21'd16, 21'd12, 21'd8, 21'd4};

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_u[$];
    exp_t q_s[$];
    exp_t mon_e;
    logic prev_u = 1'b0;
    logic prev_s = 1'b0;

    simd_mac_array_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_if ();
    simd_mac_array_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) s_if ();

    simd_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SIGNED(1'b0))
        u_dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .io(u_if));
    simd_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SIGNED(1'b1))
        s_dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .io(s_if));

    assign s_if.ap_ce       = u_if.ap_ce;
    assign s_if.ap_start    = u_if.ap_start;
    assign s_if.ap_continue = u_if.ap_continue;
    assign s_if.len         = u_if.len;
    assign s_if.a_data      = u_if.a_data;
    assign s_if.b_data      = u_if.b_data;
    assign s_if.in_vld      = u_if.in_vld;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Result monitor: pops one expectation per rising acc_ap_vld
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            chk("u_vld_eq_done", 128'(u_if.acc_ap_vld), 128'(u_if.ap_done));
            chk("s_vld_eq_done", 128'(s_if.acc_ap_vld), 128'(s_if.ap_done));
        end
        if (u_if.acc_ap_vld && !prev_u) begin
            chk("u_done_expected", 128'(q_u.size() != 0), 1);
            if (q_u.size() != 0) begin
                mon_e = q_u.pop_front();
                chk("u_acc", 128'(u_if.acc_out), 128'(mon_e.acc));
                chk("u_ovf", 128'(u_if.ovf), 128'(mon_e.ovf));
            end
        end
        if (s_if.acc_ap_vld && !prev_s) begin
            chk("s_done_expected", 128'(q_s.size() != 0), 1);
            if (q_s.size() != 0) begin
                mon_e = q_s.pop_front();
                chk("s_acc", 128'(s_if.acc_out), 128'(mon_e.acc));
                chk("s_ovf", 128'(s_if.ovf), 128'(mon_e.ovf));
            end
        end
        prev_u = u_if.acc_ap_vld;
        prev_s = s_if.acc_ap_vld;
    end

    // One complete task: accept, beats with optional gaps, drain, hold, continue
    task automatic run_task(input int n, input dat_bus_t a, input dat_bus_t b,
                            input int vgap_in, input int cgap_in, input bit hold_vld,
                            input int cont_delay, input bit start_hold,
                            input acc_bus_t eu, input logic [LANES-1:0] ou,
                            input acc_bus_t es, input logic [LANES-1:0] os);
        int   beats;
        int   vgap;
        int   cgap;
        int   guard;
        int   acc_cyc;
        bit   beat;
        exp_t e;
        vgap = vgap_in;
        cgap = cgap_in;
        u_if.len      = LEN_W'(n);
        u_if.a_data   = a;
        u_if.b_data   = b;
        u_if.in_vld   = 1'b0;
        u_if.ap_ce    = 1'b1;
        u_if.ap_start = 1'b1;
        #1;
        chk("idle_before_accept", 128'(u_if.ap_idle), 1);
        chk("ready_pulse", 128'(u_if.ap_ready), 1);
        @(posedge ap_clk); #1;
        u_if.ap_start = 1'b0;
        acc_cyc = cyc;
        #1;
        chk("idle_low_after_accept", 128'(u_if.ap_idle), 0);
        chk("u_acc_cleared", 128'(u_if.acc_out), 0);
        chk("u_ovf_cleared", 128'(u_if.ovf), 0);
        chk("s_ovf_cleared", 128'(s_if.ovf), 0);

        beats = 0;
        guard = 0;
        while (beats < n && guard < 200) begin
            if (beats == 1 && vgap > 0) begin
                u_if.in_vld = 1'b0; u_if.ap_ce = 1'b1; vgap--;
            end else if (beats == 2 && cgap > 0) begin
                u_if.in_vld = 1'b1; u_if.ap_ce = 1'b0; cgap--;
            end else begin
                u_if.in_vld = 1'b1; u_if.ap_ce = 1'b1;
            end
            beat = u_if.in_vld && u_if.ap_ce && u_if.in_rdy;
            @(posedge ap_clk); #1;
            if (beat) beats++;
            guard++;
        end
        u_if.ap_ce  = 1'b1;
        u_if.in_vld = hold_vld;
        chk("beats_accepted", 128'(beats), 128'(n));
        chk("in_rdy_low_after_last", 128'(u_if.in_rdy), 0);
        e.acc = eu; e.ovf = ou; q_u.push_back(e);
        e.acc = es; e.ovf = os; q_s.push_back(e);

        guard = 0;
        while (u_if.ap_done !== 1'b1 && guard < 60) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        chk("done_latency", 128'(cyc - acc_cyc), 128'(n + 2 + vgap_in + cgap_in));
        chk("s_done", 128'(s_if.ap_done), 1);
        chk("idle_low_in_done", 128'(u_if.ap_idle), 0);

        u_if.in_vld = 1'b0;
        for (int i = 0; i < cont_delay; i++) begin
            if (start_hold) u_if.ap_start = 1'b1;
            #1;
            chk("no_ready_in_done", 128'(u_if.ap_ready), 0);
            chk("done_held", 128'(u_if.ap_done), 1);
            chk("u_acc_stable", 128'(u_if.acc_out), 128'(eu));
            chk("s_acc_stable", 128'(s_if.acc_out), 128'(es));
            @(posedge ap_clk); #1;
        end
        u_if.ap_continue = 1'b1;
        if (start_hold) u_if.ap_start = 1'b1;
        @(posedge ap_clk); #1;
        u_if.ap_continue = 1'b0;
        chk("idle_after_continue", 128'(u_if.ap_idle), 1);
        chk("done_cleared", 128'(u_if.ap_done), 0);
        if (start_hold) chk("ready_first_idle", 128'(u_if.ap_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.ap_ce       = 1'b1;
        u_if.ap_start    = 1'b1;
        u_if.ap_continue = 1'b0;
        u_if.len         = '0;
        u_if.a_data      = '0;
        u_if.b_data      = '0;
        u_if.in_vld      = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        // Reset values, with ap_start asserted to show ap_ready stays low
        chk("rst_in_rdy", 128'(u_if.in_rdy), 0);
        chk("rst_ap_ready", 128'(u_if.ap_ready), 0);
        chk("rst_ap_done", 128'(u_if.ap_done), 0);
        chk("rst_acc_vld", 128'(u_if.acc_ap_vld), 0);
        chk("rst_acc_out", 128'(u_if.acc_out), 0);
        chk("rst_ovf", 128'(u_if.ovf), 0);
        chk("rst_ap_idle", 128'(u_if.ap_idle), 1);
        u_if.ap_start = 1'b0;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;

        // ap_start while ap_ce is low must not be accepted
        u_if.ap_ce    = 1'b0;
        u_if.ap_start = 1'b1;
        u_if.len      = 8'd4;
        #1;
        chk("ce_low_no_ready", 128'(u_if.ap_ready), 0);
        @(posedge ap_clk); #1;
        chk("ce_low_still_idle", 128'(u_if.ap_idle), 1);
        chk("ce_low_no_ready2", 128'(u_if.ap_ready), 0);
        u_if.ap_start = 1'b0;
        u_if.ap_ce    = 1'b1;

        // Basic task
        run_task(4, A_BASIC, B_TWO, 0, 0, 1'b1, 0, 1'b0, EXP_BASIC, 4'h0, EXP_BASIC, 4'h0);
        // Same task with in_vld and ap_ce gaps
        run_task(4, A_BASIC, B_TWO, 3, 2, 1'b1, 0, 1'b0, EXP_BASIC, 4'h0, EXP_BASIC, 4'h0);
        // Accumulator wrap: 33 * 255*255 mod 2^21 unsigned; 33 * (-1*-1) signed
        run_task(33, {4{8'hFF}}, {4{8'hFF}}, 0, 0, 1'b0, 0, 1'b0,
                 {4{21'd48673}}, 4'hF, {4{21'd33}}, 4'h0);
        // -3 * 5 over 3 beats; unsigned view is 253*5*3
        run_task(3, {4{8'hFD}}, {4{8'h05}}, 0, 0, 1'b0, 0, 1'b0,
                 {4{21'd3795}}, 4'h0, {4{21'h1FFFD3}}, 4'h0);
        // Zero-length task, result held 10 cycles with ap_start held high
        run_task(0, A_BASIC, B_TWO, 0, 0, 1'b0, 10, 1'b1, '0, 4'h0, '0, 4'h0);
        // Follow-on task accepted in the first IDLE cycle
        run_task(4, A_BASIC, B_TWO, 0, 0, 1'b0, 0, 1'b0, EXP_BASIC, 4'h0, EXP_BASIC, 4'h0);

        // Reset in the middle of a task
        u_if.len      = 8'd4;
        u_if.a_data   = A_BASIC;
        u_if.b_data   = B_TWO;
        u_if.ap_start = 1'b1;
        @(posedge ap_clk); #1;
        u_if.ap_start = 1'b0;
        u_if.in_vld   = 1'b1;
        repeat (3) begin
            @(posedge ap_clk); #1;
        end
        chk("u_partial_acc", 128'(u_if.acc_out), 128'(EXP_PART));
        chk("s_partial_acc", 128'(s_if.acc_out), 128'(EXP_PART));
        #2 ap_rst = 1'b1;
        #1;
        chk("mid_rst_in_rdy", 128'(u_if.in_rdy), 0);
        chk("mid_rst_ap_done", 128'(u_if.ap_done), 0);
        chk("mid_rst_acc_out", 128'(u_if.acc_out), 0);
        chk("mid_rst_s_acc_out", 128'(s_if.acc_out), 0);
        chk("mid_rst_ovf", 128'(u_if.ovf), 0);
        chk("mid_rst_ap_idle", 128'(u_if.ap_idle), 1);
        @(posedge ap_clk); #1;
        ap_rst      = 1'b0;
        u_if.in_vld = 1'b0;
        repeat (8) begin
            @(posedge ap_clk); #1;
            chk("no_done_after_abort", 128'(u_if.ap_done), 0);
        end

        // Clean task after the abort
        run_task(4, A_BASIC, B_TWO, 0, 0, 1'b0, 0, 1'b0, EXP_BASIC, 4'h0, EXP_BASIC, 4'h0);

        repeat (3) @(posedge ap_clk);
        #1;
        chk("u_queue_drained", 128'(q_u.size()), 0);
        chk("s_queue_drained", 128'(q_s.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
